mem_stage_pipelined: RTL and testbench
======================================

# mem_stage_pipelined

Parametrised MIPS memory stage: the data memory and the MEM/WB pipeline register in one block, sitting between the EX/MEM register and the write-back mux. It adds byte, halfword and word loads and stores with sign or zero extension, and detects misaligned accesses. It models a configurable number of memory wait states with a stall handshake to the hazard unit, and provides a synchronous flush of the MEM/WB register.

## Interface
- DATA_W, 32: datapath width; must be 32.
- ADDR_W, 8: word-address bits; memory holds 2**ADDR_W words.
- REG_W, 5: register-number width.
- WAIT_STATES, 0: extra cycles per memory access, 0..7.

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM
- MemWriteM  in  1  store in MEM
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemSignedM  in  1  1 = sign-extend loads, 0 = zero-extend
- RegWriteM, MemToRegM  in  1  control passed to WB
- WriteRegM  in  REG_W  destination register
- WriteDataM  in  DATA_W  store data, right-aligned
- ALUresultM  in  DATA_W  byte address, or ALU result
- FlushW  in  1  load a bubble into MEM/WB
- StallM  out  1  access in progress; hazard unit freezes PC, IF/ID, ID/EX, EX/MEM
- RegWriteW, MemToRegW  out  1  registered control
- WriteRegW  out  REG_W  registered destination
- ALUresultW  out  DATA_W  registered ALU result
- ReadDataW  out  DATA_W  registered, extended load data
- MisalignW  out  1  registered; instruction in WB faulted

## Operation
- Addressing:
  - word index = ALUresultM[ADDR_W+1:2]; lane = ALUresultM[1:0].
  - Upper address bits are ignored, so addresses wrap modulo the memory size.
- Alignment:
  - half needs lane[0]=0; word needs lane=00.
  - A misaligned access is not performed: no write, RegWrite forced to 0 in WB, MisalignW=1, no wait states.
- Access = (MemReadM | MemWriteM) and aligned. If both are set, the access is treated as a store; the load result is ignored.
- Stores use per-byte write enables:
  - byte: WriteDataM[7:0] to the lane.
  - half: WriteDataM[15:0] to lanes {lane+1, lane}.
  - word: all four lanes.
  - Unwritten bytes are unchanged.
- Loads select the addressed byte or half (little-endian lanes), then extend per MemSignedM. Word loads are never extended.
- Memory array is not reset; its contents are undefined after power-up.
- FSM states are IDLE and WAIT, with a 3-bit counter cnt.
  - IDLE, no access or WAIT_STATES=0: StallM=0; the access completes this cycle.
  - IDLE, access and WAIT_STATES>0: StallM=1; cnt<=WAIT_STATES-1; go to WAIT.
  - WAIT, cnt!=0: StallM=1; cnt<=cnt-1.
  - WAIT, cnt==0: StallM=0; the access completes; go to IDLE.
- Completion:
  - A store's write commits exactly once, on the completing edge.
  - Load data is taken from the array in the completing cycle.
- MEM/WB register, per edge, in priority order:
  - FlushW=1 loads a bubble.
  - Otherwise StallM=1 loads a bubble.
  - Otherwise it captures the M-stage values.
- A bubble sets all controls, MisalignW, WriteRegW and the data fields to 0.
- FlushW affects only the MEM/WB register. The FSM continues and the write still commits.
- The M-stage inputs must stay stable while StallM=1. The block does not re-latch them.

## Timing
- Reset (RST_N=0, asynchronous): FSM goes to IDLE, cnt=0, StallM=0, and every W output is 0.
- Reset mid-access aborts the access with no memory write.
- StallM is combinational from the FSM state and M inputs; it is valid in the same cycle.
- Latency:
  - non-memory instruction and WAIT_STATES=0 access: 1 cycle into W.
  - access with WAIT_STATES=N: N+1 cycles, StallM high for the first N.
- Back-to-back accesses each incur the full N+1 cycles; there are no idle cycles between them.
- ReadDataW holds the data read at completion, including a store to the same word that completes in that same cycle (old data is read; write-after-read).

## Test plan
- WAIT_STATES=0: sw 0xDEADBEEF to addr 0x10, then lw 0x10 -> ReadDataW=0xDEADBEEF the cycle after the load; StallM never high.
- Byte and half loads, mem[0x10]=0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE.
  - lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- sb 0x55 to 0x11 over 0xDEADBEEF -> lw 0x10 returns 0xDEAD55EF.
- Misalignment: lw 0x12 and sh 0x11 -> MisalignW=1, RegWriteW=0, memory unchanged, StallM=0 even with WAIT_STATES=3.
- WAIT_STATES=3:
  - sw then lw -> StallM high exactly 3 cycles per access; W shows bubbles during the stall; the store is written once; the load returns the stored value.
  - RST_N low in the 2nd stall cycle of a sw -> outputs 0 and the target word is unchanged.
- FlushW=1 on an lw completion edge -> W holds a bubble (RegWriteW=0) and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_stage_pipelined_if.sv
// ----------------------------------------------------------------------------
// mem_stage_pipelined_if
// Bundles the M-stage inputs and the MEM/WB outputs of the memory stage.
//   master : pipeline side. Drives the EX/MEM values and FlushW. Receives
//            StallM and the registered W-stage values.
//   slave  : memory stage side. This is the direction used by
//            mem_stage_pipelined.
// M-stage signals: MemReadM, MemWriteM, MemSizeM, MemSignedM, RegWriteM,
//                  MemToRegM, WriteRegM, WriteDataM, ALUresultM
// Control in     : FlushW
// Outputs        : StallM, RegWriteW, MemToRegW, WriteRegW, ALUresultW,
//                  ReadDataW, MisalignW
// ----------------------------------------------------------------------------
interface mem_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              MemReadM;
  logic              MemWriteM;
  logic [1:0]        MemSizeM;
  logic              MemSignedM;
  logic              RegWriteM;
  logic              MemToRegM;
  logic [REG_W-1:0]  WriteRegM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] ALUresultM;
  logic              FlushW;

  logic              StallM;
  logic              RegWriteW;
  logic              MemToRegW;
  logic [REG_W-1:0]  WriteRegW;
  logic [DATA_W-1:0] ALUresultW;
  logic [DATA_W-1:0] ReadDataW;
  logic              MisalignW;

  modport master (
    output MemReadM, MemWriteM, MemSizeM, MemSignedM, RegWriteM, MemToRegM,
           WriteRegM, WriteDataM, ALUresultM, FlushW,
    input  StallM, RegWriteW, MemToRegW, WriteRegW, ALUresultW, ReadDataW,
           MisalignW
  );

  modport slave (
    input  MemReadM, MemWriteM, MemSizeM, MemSignedM, RegWriteM, MemToRegM,
           WriteRegM, WriteDataM, ALUresultM, FlushW,
    output StallM, RegWriteW, MemToRegW, WriteRegW, ALUresultW, ReadDataW,
           MisalignW
  );
endinterface

// File: rtl/mem_stage_pipelined.sv
// ----------------------------------------------------------------------------
// mem_stage_pipelined
// MIPS memory stage. It holds the data memory and the MEM/WB pipeline
// register. It supports byte, half and word loads and stores with sign or
// zero extension, and it detects misaligned accesses. Each access can take
// WAIT_STATES extra cycles. During those cycles StallM freezes the earlier
// pipeline stages.
// Parameters: DATA_W (must be 32), ADDR_W (word-address bits),
//             REG_W (register number width), WAIT_STATES (0..7)
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : mem_stage_pipelined_if.slave. It carries the M-stage inputs,
//           FlushW, StallM and the registered W-stage outputs.
// ----------------------------------------------------------------------------
module mem_stage_pipelined #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int REG_W       = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  mem_stage_pipelined_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] memArray [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        lane;
  logic              isByte, isHalf, isWord;
  logic              memOp, misalign, access;
  logic              stall, complete;
  logic [3:0]        byteEn;
  logic [DATA_W-1:0] wdataLanes;
  logic [DATA_W-1:0] rdWord;
  logic [7:0]        rdByte;
  logic [15:0]       rdHalf;
  logic [DATA_W-1:0] loadData;
  logic              unusedAddrBits;

  // Address decode. The upper address bits are dropped, so addresses wrap
  // around the memory size.
  assign wordIdx        = bus.ALUresultM[ADDR_W+1:2];
  assign lane           = bus.ALUresultM[1:0];
  assign unusedAddrBits = ^bus.ALUresultM[DATA_W-1:ADDR_W+2];

  assign isByte = (bus.MemSizeM == 2'b00);
  assign isHalf = (bus.MemSizeM == 2'b01);
  assign isWord = bus.MemSizeM[1];

  // A misaligned access is never performed, so it never stalls.
  assign memOp    = bus.MemReadM | bus.MemWriteM;
  assign misalign = memOp & ((isHalf & lane[0]) | (isWord & (lane != 2'b00)));
  assign access   = memOp & ~misalign;

  // FSM state register. The counter counts the remaining stall cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall/complete decode. StallM is gated by RST_N so that
  // it reads 0 while reset is held, even if an access is presented.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && RST_N) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 3'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.StallM = stall;

  // Store lane steering. Narrow data is replicated across all lanes, and
  // the byte enables pick the lanes that are written.
  always_comb begin
    byteEn     = 4'b0000;
    wdataLanes = bus.WriteDataM;
    if (isByte) begin
      byteEn     = 4'b0001 << lane;
      wdataLanes = {4{bus.WriteDataM[7:0]}};
    end else if (isHalf) begin
      byteEn     = 4'b0011 << lane;
      wdataLanes = {2{bus.WriteDataM[15:0]}};
    end else begin
      byteEn     = 4'b1111;
    end
  end

  // Data memory. It has no reset. A store commits once, on the completing
  // edge. Gating with RST_N stops a reset from landing a partial access.
  always_ff @(posedge CLK) begin
    if (RST_N && complete && access && bus.MemWriteM) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          memArray[wordIdx][8*b +: 8] <= wdataLanes[8*b +: 8];
        end
      end
    end
  end

  // Load path. The array is read combinationally, so a store that completes
  // on the same edge is seen as old data. A combined read and write counts
  // as a store, and its load result is dropped.
  assign rdWord = memArray[wordIdx];
  assign rdByte = rdWord[{lane, 3'b000} +: 8];
  assign rdHalf = rdWord[{lane[1], 4'b0000} +: 16];

  always_comb begin
    loadData = '0;
    if (access && bus.MemReadM && !bus.MemWriteM) begin
      if (isByte) begin
        loadData = {{24{bus.MemSignedM & rdByte[7]}}, rdByte};
      end else if (isHalf) begin
        loadData = {{16{bus.MemSignedM & rdHalf[15]}}, rdHalf};
      end else begin
        loadData = rdWord;
      end
    end
  end

  // MEM/WB register. A flush has priority over a stall bubble, and a stall
  // bubble has priority over capturing the M-stage values. A faulting
  // instruction never writes the register file.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.RegWriteW  <= 1'b0;
      bus.MemToRegW  <= 1'b0;
      bus.WriteRegW  <= '0;
      bus.ALUresultW <= '0;
      bus.ReadDataW  <= '0;
      bus.MisalignW  <= 1'b0;
    end else if (bus.FlushW || stall) begin
      bus.RegWriteW  <= 1'b0;
      bus.MemToRegW  <= 1'b0;
      bus.WriteRegW  <= '0;
      bus.ALUresultW <= '0;
      bus.ReadDataW  <= '0;
      bus.MisalignW  <= 1'b0;
    end else begin
      bus.RegWriteW  <= bus.RegWriteM & ~misalign;
      bus.MemToRegW  <= bus.MemToRegM;
      bus.WriteRegW  <= bus.WriteRegM;
      bus.ALUresultW <= bus.ALUresultM;
      bus.ReadDataW  <= loadData;
      bus.MisalignW  <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipelined.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_pipelined
// Drives two memory stages. dut0 has no wait states and runs a table of
// single-cycle vectors. dut3 has three wait states and runs hand-written
// multi-cycle sequences: back-to-back accesses, a misaligned access, a
// reset in the middle of an access, and a flush on the completing edge.
// ----------------------------------------------------------------------------
module tb_mem_stage_pipelined;

  logic CLK;
  logic rstN0, rstN3;

  int checks   = 0;
  int failures = 0;

  mem_stage_pipelined_if #(.DATA_W(32), .REG_W(5)) if0 ();
  mem_stage_pipelined_if #(.DATA_W(32), .REG_W(5)) if3 ();

  mem_stage_pipelined #(.DATA_W(32), .ADDR_W(8), .REG_W(5), .WAIT_STATES(0)) dut0 (
    .CLK   (CLK),
    .RST_N (rstN0),
    .bus   (if0.slave)
  );

  mem_stage_pipelined #(.DATA_W(32), .ADDR_W(8), .REG_W(5), .WAIT_STATES(3)) dut3 (
    .CLK   (CLK),
    .RST_N (rstN3),
    .bus   (if3.slave)
  );

  // Free-running 10 ns clock shared by both instances.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic        regW;
    logic        m2r;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] expRead;
    logic        expRegW;
    logic        expMis;
  } vec_t;

  vec_t vecQ[$];

  // Single comparison. Every mismatch prints one FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic rd, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic regW, input logic m2r, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] expRead,
                        input logic expRegW, input logic expMis);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.regW = regW;
    v.m2r = m2r; v.wreg = wreg; v.wdata = wdata; v.addr = addr; v.expRead = expRead;
    v.expRegW = expRegW; v.expMis = expMis;
    vecQ.push_back(v);
  endtask

  task automatic setIdle0();
    if0.MemReadM = 0; if0.MemWriteM = 0; if0.MemSizeM = 2'b10; if0.MemSignedM = 0;
    if0.RegWriteM = 0; if0.MemToRegM = 0; if0.WriteRegM = '0; if0.WriteDataM = '0;
    if0.ALUresultM = '0; if0.FlushW = 0;
  endtask

  task automatic setIdle3();
    if3.MemReadM = 0; if3.MemWriteM = 0; if3.MemSizeM = 2'b10; if3.MemSignedM = 0;
    if3.RegWriteM = 0; if3.MemToRegM = 0; if3.WriteRegM = '0; if3.WriteDataM = '0;
    if3.ALUresultM = '0; if3.FlushW = 0;
  endtask

  // Applies one single-cycle vector to dut0 and checks the W stage.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    if0.MemReadM = v.rd; if0.MemWriteM = v.wr; if0.MemSizeM = v.size; if0.MemSignedM = v.sgn;
    if0.RegWriteM = v.regW; if0.MemToRegM = v.m2r; if0.WriteRegM = v.wreg;
    if0.WriteDataM = v.wdata; if0.ALUresultM = v.addr; if0.FlushW = 0;
    #1;
    checkOutput({v.name, " StallM"}, 32'(if0.StallM), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput({v.name, " ReadDataW"}, if0.ReadDataW, v.expRead);
    checkOutput({v.name, " RegWriteW"}, 32'(if0.RegWriteW), 32'(v.expRegW));
    checkOutput({v.name, " MisalignW"}, 32'(if0.MisalignW), 32'(v.expMis));
    checkOutput({v.name, " ALUresultW"}, if0.ALUresultW, v.addr);
    checkOutput({v.name, " WriteRegW"}, 32'(if0.WriteRegW), 32'(v.wreg));
    checkOutput({v.name, " MemToRegW"}, 32'(if0.MemToRegW), 32'(v.m2r));
  endtask

  // Runs one access on dut3. It counts the stall cycles, checks for bubbles
  // while stalled, and checks the W stage after the completing edge. When
  // flush is set, FlushW is raised in the completing cycle.
  task automatic access3(input string name, input logic rd, input logic wr, input logic [1:0] size,
                         input logic sgn, input logic regW, input logic [31:0] wdata,
                         input logic [31:0] addr, input logic flush, input int expStalls,
                         input logic [31:0] expRead, input logic expRegW, input logic expMis);
    int  stalls = 0;
    bit  done   = 0;
    @(negedge CLK);
    if3.MemReadM = rd; if3.MemWriteM = wr; if3.MemSizeM = size; if3.MemSignedM = sgn;
    if3.RegWriteM = regW; if3.MemToRegM = rd; if3.WriteRegM = 5'd9;
    if3.WriteDataM = wdata; if3.ALUresultM = addr; if3.FlushW = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (if3.StallM) begin
        stalls++;
        @(posedge CLK);
        #1;
        checkOutput({name, " bubble RegWriteW"}, 32'(if3.RegWriteW), 32'd0);
        checkOutput({name, " bubble ALUresultW"}, if3.ALUresultW, 32'd0);
        @(negedge CLK);
      end else begin
        if3.FlushW = flush;
        @(posedge CLK);
        #1;
        done = 1;
      end
    end
    checkOutput({name, " completed"}, 32'(done), 32'd1);
    checkOutput({name, " stall cycles"}, 32'(stalls), 32'(expStalls));
    checkOutput({name, " ReadDataW"}, if3.ReadDataW, flush ? 32'd0 : expRead);
    checkOutput({name, " RegWriteW"}, 32'(if3.RegWriteW), flush ? 32'd0 : 32'(expRegW));
    checkOutput({name, " MisalignW"}, 32'(if3.MisalignW), flush ? 32'd0 : 32'(expMis));
    checkOutput({name, " ALUresultW"}, if3.ALUresultW, flush ? 32'd0 : addr);
    checkOutput({name, " WriteRegW"}, 32'(if3.WriteRegW), flush ? 32'd0 : 32'd9);
  endtask

  // Main sequence: reset, the dut0 vector table, then the dut3 sequences.
  initial begin
    rstN0 = 0;
    rstN3 = 0;
    setIdle0();
    setIdle3();

    //     name        rd wr size  sg rw m2r reg   wdata          addr           expRead        rw mis
    addVec("sw 0x10",   0, 1, 2'b10, 0, 0, 0, 5'd0, 32'hDEADBEEF, 32'h00000010, 32'h00000000, 0, 0);
    addVec("lw 0x10",   1, 0, 2'b10, 0, 1, 1, 5'd8, 32'h0,        32'h00000010, 32'hDEADBEEF, 1, 0);
    addVec("lb 0x13",   1, 0, 2'b00, 1, 1, 1, 5'd9, 32'h0,        32'h00000013, 32'hFFFFFFDE, 1, 0);
    addVec("lbu 0x13",  1, 0, 2'b00, 0, 1, 1, 5'd10, 32'h0,       32'h00000013, 32'h000000DE, 1, 0);
    addVec("lh 0x10",   1, 0, 2'b01, 1, 1, 1, 5'd11, 32'h0,       32'h00000010, 32'hFFFFBEEF, 1, 0);
    addVec("lhu 0x12",  1, 0, 2'b01, 0, 1, 1, 5'd12, 32'h0,       32'h00000012, 32'h0000DEAD, 1, 0);
    addVec("sb 0x11",   0, 1, 2'b00, 0, 0, 0, 5'd0, 32'h12345655, 32'h00000011, 32'h00000000, 0, 0);
    addVec("lw after sb", 1, 0, 2'b10, 0, 1, 1, 5'd13, 32'h0,     32'h00000010, 32'hDEAD55EF, 1, 0);
    addVec("lw 0x12 mis", 1, 0, 2'b10, 0, 1, 1, 5'd14, 32'h0,     32'h00000012, 32'h00000000, 0, 1);
    addVec("sh 0x11 mis", 0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h0000AAAA, 32'h00000011, 32'h00000000, 0, 1);
    addVec("lw unchanged", 1, 0, 2'b10, 0, 1, 1, 5'd15, 32'h0,    32'h00000010, 32'hDEAD55EF, 1, 0);
    addVec("alu op",    0, 0, 2'b10, 0, 1, 0, 5'd16, 32'h0,       32'h00001234, 32'h00000000, 1, 0);
    addVec("lw wrap",   1, 0, 2'b10, 0, 1, 1, 5'd17, 32'h0,       32'h00000410, 32'hDEAD55EF, 1, 0);
    addVec("sh 0x12",   0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h1111CAFE, 32'h00000012, 32'h00000000, 0, 0);
    addVec("lw after sh", 1, 0, 2'b10, 0, 1, 1, 5'd18, 32'h0,     32'h00000010, 32'hCAFE55EF, 1, 0);
    addVec("lsize11",   1, 0, 2'b11, 1, 1, 1, 5'd19, 32'h0,       32'h00000010, 32'hCAFE55EF, 1, 0);

    #12;
    checkOutput("reset StallM", 32'(if3.StallM), 32'd0);
    checkOutput("reset RegWriteW", 32'(if3.RegWriteW), 32'd0);
    checkOutput("reset ReadDataW", if3.ReadDataW, 32'd0);
    checkOutput("reset ALUresultW", if3.ALUresultW, 32'd0);
    checkOutput("reset MisalignW", 32'(if0.MisalignW), 32'd0);
    checkOutput("reset WriteRegW", 32'(if0.WriteRegW), 32'd0);
    @(negedge CLK);
    rstN0 = 1;
    rstN3 = 1;

    foreach (vecQ[i]) applyStimulus(vecQ[i]);
    @(negedge CLK);
    setIdle0();

    // Wait-state sequences on dut3. The stores and loads run back to back.
    access3("ws sw 0x20", 0, 1, 2'b10, 0, 0, 32'h11223344, 32'h20, 0, 3, 32'h0, 0, 0);
    access3("ws lw 0x20", 1, 0, 2'b10, 0, 1, 32'h0, 32'h20, 0, 3, 32'h11223344, 1, 0);
    access3("ws sb 0x20", 0, 1, 2'b00, 0, 0, 32'h000000F0, 32'h20, 0, 3, 32'h0, 0, 0);
    access3("ws lb 0x20", 1, 0, 2'b00, 1, 1, 32'h0, 32'h20, 0, 3, 32'hFFFFFFF0, 1, 0);
    access3("ws lw mis", 1, 0, 2'b10, 0, 1, 32'h0, 32'h22, 0, 0, 32'h0, 0, 1);
    access3("ws sw 0x30", 0, 1, 2'b10, 0, 0, 32'hA5A5A5A5, 32'h30, 0, 3, 32'h0, 0, 0);

    // Reset in the second stall cycle of a store.
    @(negedge CLK);
    if3.MemReadM = 0; if3.MemWriteM = 1; if3.MemSizeM = 2'b10; if3.RegWriteM = 0;
    if3.WriteDataM = 32'h5A5A5A5A; if3.ALUresultM = 32'h30; if3.FlushW = 0;
    @(posedge CLK);
    #2;
    rstN3 = 0;
    #1;
    checkOutput("rst mid StallM", 32'(if3.StallM), 32'd0);
    checkOutput("rst mid RegWriteW", 32'(if3.RegWriteW), 32'd0);
    checkOutput("rst mid ALUresultW", if3.ALUresultW, 32'd0);
    checkOutput("rst mid ReadDataW", if3.ReadDataW, 32'd0);
    @(negedge CLK);
    setIdle3();
    @(negedge CLK);
    rstN3 = 1;
    access3("ws lw after rst", 1, 0, 2'b10, 0, 1, 32'h0, 32'h30, 0, 3, 32'hA5A5A5A5, 1, 0);

    // Flush on the completing edge of a load. The next load shows the
    // FSM is back in IDLE.
    access3("ws lw flush", 1, 0, 2'b10, 0, 1, 32'h0, 32'h20, 1, 3, 32'h0, 0, 0);
    access3("ws lw post flush", 1, 0, 2'b10, 0, 1, 32'h0, 32'h20, 0, 3, 32'h112233F0, 1, 0);

    @(negedge CLK);
    setIdle3();
    #1;
    checkOutput("idle StallM", 32'(if3.StallM), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
